// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer and the pipeline
// registers it controls.
//   state_e      : sequencer state, 2-bit encoding
//   REG_W        : register-specifier width
//   wb_ctrl_t    : MEM/WB write-back control fields
//   WB_BUBBLE    : value the MEM/WB register loads when bubbled
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_e;

    typedef struct packed {
        logic reg_write;
        logic cond_mov;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{reg_write: 1'b0, cond_mov: 1'b0, mem_to_reg: 1'b0};

    // Data-memory access still outstanding in MEM.
    function automatic logic dm_stall_f(input logic dm_req, input logic dm_ready);
        return dm_req & ~dm_ready;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the sequencer.
//   master : pipeline side, drives hazard inputs, receives stall/flush controls
//   slave  : sequencer side
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_W-1:0] ID_Rs;
    logic [REG_W-1:0] ID_Rt;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [REG_W-1:0] EX_WriteRegister;
    logic             MEM_BranchTaken;
    logic             MEM_DMReq;
    logic             DM_Ready;

    logic             PC_Write;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Write;
    logic             IDEX_Flush;
    logic             EXMEM_Write;
    logic             EXMEM_Flush;
    logic             MEMWB_Write;
    logic             MEMWB_Bubble;
    logic             MemTimeout;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWrite, EX_WriteRegister,
               MEM_BranchTaken, MEM_DMReq, DM_Ready,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, EXMEM_Flush, MEMWB_Write, MEMWB_Bubble,
               MemTimeout, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegWrite, EX_WriteRegister,
               MEM_BranchTaken, MEM_DMReq, DM_Ready,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
               EXMEM_Write, EXMEM_Flush, MEMWB_Write, MEMWB_Bubble,
               MemTimeout, StallCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
// Load-use comparator: flags an ID-stage instruction that reads the
// destination of a load currently in EX.
//   id_rs_i, id_rt_i, id_uses_rt_i          : ID-stage sources
//   ex_mem_read_i, ex_reg_write_i, ex_wr_reg_i : EX-stage load info
//   load_use_o                               : hazard present
module hazard_load_use_det
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_mem_read_i,
    input  logic             ex_reg_write_i,
    input  logic [REG_W-1:0] ex_wr_reg_i,
    output logic             load_use_o
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use_o = ex_mem_read_i & ex_reg_write_i & (ex_wr_reg_i != '0) &
                        ((ex_wr_reg_i == id_rs_i) | (id_uses_rt_i & (ex_wr_reg_i == id_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   Clk, Rst_n : clock, async active-low reset
//   hz         : hazard inputs in, pipeline-register write/flush controls out,
//                sticky MemTimeout and saturating StallCount
//
// state       | meaning
// ------------+-----------------------------------------------
// ST_RUN      | normal flow, hazards resolved combinationally
// ST_MEM_WAIT | data-memory access outstanding, pipeline held
// ST_ERROR    | memory timed out, pipeline frozen until reset
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic dm_stall;
    logic load_use;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic exmem_write, exmem_flush, memwb_write, memwb_bubble;

    assign dm_stall = dm_stall_f(hz.MEM_DMReq, hz.DM_Ready);

    hazard_load_use_det u_load_use_det (
        .id_rs_i        (hz.ID_Rs),
        .id_rt_i        (hz.ID_Rt),
        .id_uses_rt_i   (hz.ID_UsesRt),
        .ex_mem_read_i  (hz.EX_MemRead),
        .ex_reg_write_i (hz.EX_RegWrite),
        .ex_wr_reg_i    (hz.EX_WriteRegister),
        .load_use_o     (load_use)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_RUN, ST_MEM_WAIT: begin
                if (dm_stall) begin
                    // DM_Ready on the last allowed cycle clears dm_stall, so it
                    // naturally wins over the timeout.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = ST_ERROR;
                        timeout_d  = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        exmem_flush  = 1'b0;
        memwb_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!Rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
        end else if (state_q == ST_ERROR) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (dm_stall) begin
            // MEM is held; MEM/WB keeps clocking but receives a bubble.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (hz.MEM_BranchTaken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cnt_q <= '0;
        end else if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign hz.PC_Write     = pc_write;
    assign hz.IFID_Write   = ifid_write;
    assign hz.IFID_Flush   = ifid_flush;
    assign hz.IDEX_Write   = idex_write;
    assign hz.IDEX_Flush   = idex_flush;
    assign hz.EXMEM_Write  = exmem_write;
    assign hz.EXMEM_Flush  = exmem_flush;
    assign hz.MEMWB_Write  = memwb_write;
    assign hz.MEMWB_Bubble = memwb_bubble;
    assign hz.MemTimeout   = timeout_q;
    assign hz.StallCount   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 4;
    localparam int TB_CNT_W   = 3;

    // {PC_W, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, EXMEM_F, MEMWB_W, MEMWB_B}
    localparam logic [8:0] O_DEF   = 9'b110101010;
    localparam logic [8:0] O_DM    = 9'b000000011;
    localparam logic [8:0] O_BR    = 9'b111111110;
    localparam logic [8:0] O_LU    = 9'b000111010;
    localparam logic [8:0] O_ERR   = 9'b000000001;
    localparam logic [8:0] O_RESET = 9'b000000000;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    pipe_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) ifc ();

    pipe_hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .hz    (ifc)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic       reg_write;
        logic [4:0] wr_reg;
        logic       br;
        logic       dm_req;
        logic       dm_ready;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [8:0] outs();
        return {ifc.PC_Write, ifc.IFID_Write, ifc.IFID_Flush, ifc.IDEX_Write, ifc.IDEX_Flush,
                ifc.EXMEM_Write, ifc.EXMEM_Flush, ifc.MEMWB_Write, ifc.MEMWB_Bubble};
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                         input logic mem_read, input logic reg_write, input logic [4:0] wr_reg,
                         input logic br, input logic dm_req, input logic dm_ready);
        ifc.ID_Rs            = rs;
        ifc.ID_Rt            = rt;
        ifc.ID_UsesRt        = uses_rt;
        ifc.EX_MemRead       = mem_read;
        ifc.EX_RegWrite      = reg_write;
        ifc.EX_WriteRegister = wr_reg;
        ifc.MEM_BranchTaken  = br;
        ifc.MEM_DMReq        = dm_req;
        ifc.DM_Ready         = dm_ready;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        Rst_n = 1'b0;
        #1;
        check("reset_outs", int'(outs()), int'(O_RESET));
        step();
        step();
        Rst_n = 1'b1;
        #1;
    endtask

    // Load-use against r5: used by several sequences.
    task automatic drive_lu();
        drive(5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        //         rs     rt     urt   mrd   rw    wr     br    req   rdy   exp
        vecs[0]  = '{5'd5, 5'd1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, O_LU};
        vecs[1]  = '{5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, O_LU};
        vecs[2]  = '{5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, O_DEF};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, O_DEF};
        vecs[4]  = '{5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, O_DEF};
        vecs[5]  = '{5'd7, 5'd2, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, O_DEF};
        vecs[6]  = '{5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, O_BR};
        vecs[7]  = '{5'd9, 5'd2, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, O_DM};
        vecs[8]  = '{5'd4, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, O_LU};
        vecs[9]  = '{5'd4, 5'd8, 1'b1, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b1, O_DEF};
        vecs[10] = '{5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR};
        vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_DEF};

        do_reset();
        check("reset_stallcnt", int'(ifc.StallCount), 0);
        check("reset_timeout", int'(ifc.MemTimeout), 0);

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read, vecs[i].reg_write,
                  vecs[i].wr_reg, vecs[i].br, vecs[i].dm_req, vecs[i].dm_ready);
            #1;
            check($sformatf("vec%0d", i), int'(outs()), int'(vecs[i].exp));
            step();
        end

        // Single-cycle load-use stall.
        do_reset();
        drive_lu();
        #1;
        check("lu_stall", int'(outs()), int'(O_LU));
        step();
        idle();
        #1;
        check("lu_next", int'(outs()), int'(O_DEF));
        check("lu_stallcnt", int'(ifc.StallCount), 1);

        // Three-cycle memory wait, release on the fourth.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dm_wait%0d", i), int'(outs()), int'(O_DM));
            step();
        end
        ifc.DM_Ready = 1'b1;
        #1;
        check("dm_release", int'(outs()), int'(O_DEF));
        step();
        idle();
        #1;
        check("dm_stallcnt", int'(ifc.StallCount), 3);
        check("dm_no_timeout", int'(ifc.MemTimeout), 0);

        // Branch held in MEM during a wait is serviced on the release cycle.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        #1;
        check("br_wait", int'(outs()), int'(O_DM));
        step();
        ifc.DM_Ready = 1'b1;
        #1;
        check("br_release", int'(outs()), int'(O_BR));
        step();

        // Timeout after TB_TIMEOUT stalled cycles, frozen until reset.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step();
        #1;
        check("to_last_wait", int'(outs()), int'(O_DM));
        check("to_not_yet", int'(ifc.MemTimeout), 0);
        step();
        check("to_error_outs", int'(outs()), int'(O_ERR));
        check("to_flag", int'(ifc.MemTimeout), 1);
        idle();
        step();
        check("to_frozen", int'(outs()), int'(O_ERR));
        check("to_sticky", int'(ifc.MemTimeout), 1);
        Rst_n = 1'b0;
        #1;
        check("to_rst_outs", int'(outs()), int'(O_RESET));
        check("to_rst_flag", int'(ifc.MemTimeout), 0);
        step();
        Rst_n = 1'b1;
        #1;
        check("to_after_rst", int'(outs()), int'(O_DEF));

        // DM_Ready on the timeout cycle wins: back to RUN, no error.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step();
        ifc.DM_Ready = 1'b1;
        step();
        idle();
        #1;
        check("to_race_outs", int'(outs()), int'(O_DEF));
        check("to_race_flag", int'(ifc.MemTimeout), 0);

        // Saturation of a 3-bit counter.
        do_reset();
        drive_lu();
        for (int i = 0; i < 7; i++) step();
        check("sat_7", int'(ifc.StallCount), 7);
        for (int i = 0; i < 3; i++) step();
        check("sat_hold", int'(ifc.StallCount), 7);

        // Reset mid-wait leaves no residual stall.
        do_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        idle();
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
        #1;
        check("midwait_outs", int'(outs()), int'(O_DEF));
        step();
        check("midwait_cnt", int'(ifc.StallCount), 0);
        check("midwait_outs2", int'(outs()), int'(O_DEF));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush/bubble controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three cases: multi-cycle data-memory waits, taken branches resolved in MEM, and load-use hazards.
- Also tracks stall cycles and raises a sticky error on a memory timeout.

Parameters:
- TIMEOUT, 64, max consecutive MEM_WAIT cycles before the block enters ERROR.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  pipeline clock; all state updates on its rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- ID_Rs  in  5  source register rs of the ID-stage instruction.
- ID_Rt  in  5  source register rt of the ID-stage instruction.
- ID_UsesRt  in  1  ID-stage instruction reads rt.
- EX_MemRead  in  1  EX-stage instruction is a load.
- EX_RegWrite  in  1  EX-stage instruction writes a register.
- EX_WriteRegister  in  5  destination register of the EX-stage instruction.
- MEM_BranchTaken  in  1  branch resolved taken in MEM.
- MEM_DMReq  in  1  MEM-stage instruction accesses data memory.
- DM_Ready  in  1  data memory completes the access this cycle.
- PC_Write  out  1  PC update enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  IF/ID register loads a NOP.
- IDEX_Write  out  1  ID/EX register load enable.
- IDEX_Flush  out  1  ID/EX register loads a bubble (all control lines 0).
- EXMEM_Write  out  1  EX/MEM register load enable.
- EXMEM_Flush  out  1  EX/MEM register loads a bubble.
- MEMWB_Write  out  1  MEM/WB register load enable.
- MEMWB_Bubble  out  1  MEM/WB register loads RegWrite=0, CondMov=0, MemtoReg=0.
- MemTimeout  out  1  sticky error flag.
- StallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Encoding is 2 bits.
- Control outputs are combinational from the current state and inputs, with zero cycle latency. State, counters and MemTimeout are registered.
- Defaults:
  - All Write outputs = 1.
  - All Flush outputs and MEMWB_Bubble = 0.
- Reset (Rst_n=0, asynchronous):
  - State = RUN, WaitCnt = 0, StallCount = 0, MemTimeout = 0.
  - All Write outputs are forced to 0 and all Flush/Bubble outputs to 0 while Rst_n is low.
- Hazard definitions:
  - dm_stall = MEM_DMReq & ~DM_Ready.
  - load_use = EX_MemRead & EX_RegWrite & (EX_WriteRegister != 0) & ((EX_WriteRegister == ID_Rs) | (ID_UsesRt & (EX_WriteRegister == ID_Rt))).
- RUN and MEM_WAIT evaluate the same priority order, highest first:
  1. dm_stall:
     - PC_Write, IFID_Write, IDEX_Write, EXMEM_Write = 0.
     - MEMWB_Bubble = 1.
     - Branch and load-use are ignored this cycle.
     - Next state = MEM_WAIT; WaitCnt increments.
  2. MEM_BranchTaken:
     - IFID_Flush, IDEX_Flush, EXMEM_Flush = 1.
     - PC_Write = 1 (the target is loaded).
     - load_use is ignored.
  3. load_use:
     - PC_Write = 0, IFID_Write = 0, IDEX_Flush = 1.
     - This lasts a single cycle; the load advances to MEM on the next cycle, so the hazard clears.
  4. Otherwise: defaults.
- MEM_WAIT exit:
  - When DM_Ready=1, the cycle behaves exactly as RUN without dm_stall: the MEM-stage result enters MEM/WB and branch/load-use rules apply.
  - Next state = RUN; WaitCnt clears.
- Timeout:
  - If WaitCnt reaches TIMEOUT-1 while dm_stall is still 1, next state = ERROR and MemTimeout is set.
  - DM_Ready arriving on that same cycle takes precedence: return to RUN, no error.
- ERROR:
  - All Write outputs = 0 and MEMWB_Bubble = 1.
  - The pipeline is frozen until reset; MemTimeout stays 1.
- StallCount:
  - Increments on every cycle where PC_Write=0 while Rst_n=1, including ERROR cycles.
  - Saturates at 2^CNT_W-1 and never wraps.
- Simultaneous events:
  - A branch in MEM during a DM wait is serviced on the release cycle, because the instruction is still held in MEM.
  - Register 0 as a load destination never stalls.
- Reset mid-wait returns to RUN with no residual stall.

Decomposition:
- Shared pipeline package holds:
  - state typedef (RUN, MEM_WAIT, ERROR);
  - REG_W=5 constant;
  - bubble control-field constants shared with the pipeline registers.
- One natural sub-module, hazard_load_use_det: the purely combinational load_use comparator.
- The FSM and counters stay in the top level.

Test Plan:
- EX load to r5, ID reads rs=r5 -> one cycle with PC_Write=0, IFID_Write=0, IDEX_Flush=1; next cycle all defaults; StallCount=1.
- Same case with EX_WriteRegister=0, or with rt match while ID_UsesRt=0 -> no stall.
- MEM_DMReq=1, DM_Ready low for 3 cycles then high -> 3 cycles of freeze with MEMWB_Bubble=1, release on the 4th cycle with MEMWB_Write=1; StallCount=3.
- MEM_BranchTaken=1 together with load_use -> IFID/IDEX/EXMEM_Flush=1, PC_Write=1, no load-use freeze.
- DM_Ready held low for TIMEOUT=4 cycles -> ERROR and MemTimeout=1, all writes 0; Rst_n pulse low -> RUN and MemTimeout=0.
- CNT_W=3, force 10 stall cycles -> StallCount holds at 7.
